// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM encoding,
// board button bit positions and default timing for a 50 MHz clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_WAIT   = 2'd1,
        HELD_REPEAT = 2'd2
    } btn_state_e;

    localparam int unsigned BTN_SOUTH = 0;
    localparam int unsigned BTN_NORTH = 1;
    localparam int unsigned BTN_WEST  = 2;
    localparam int unsigned BTN_EAST  = 3;

    localparam int unsigned DEF_NUM_BTN       = 4;
    localparam int unsigned DEF_DEBOUNCE_CYC  = 500000;
    localparam int unsigned DEF_REPEAT_DELAY  = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD = 7500000;
    localparam int unsigned DEF_CNT_W         = 25;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce counter and the
// press / auto-repeat FSM. Pulse "next" values feed the shared flag register.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rpt,
    output logic press_next,
    output logic rpt_next
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] dc_q, dc_d;
    logic [CNT_W-1:0] rc_q, rc_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rpt_q, rpt_d;
    btn_state_e       state_q, state_d;
    logic             rise, fall;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        dc_d    = dc_q;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (sync_q[1] == level_q) begin
            dc_d = '0;
        end else if (dc_q == DB_LAST) begin
            dc_d    = '0;
            level_d = ~level_q;
            rise    = ~level_q;
            fall    = level_q;
        end else begin
            dc_d = dc_q + CNT_W'(1);
        end
    end

    // An accepted release is tested first so it overrides a repeat tick due on the same edge.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        press_d = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HELD_WAIT;
                    rc_d    = '0;
                    press_d = 1'b1;
                end
            end
            HELD_WAIT: begin
                if (fall) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == RD_LAST) begin
                    state_d = HELD_REPEAT;
                    rc_d    = '0;
                    rpt_d   = 1'b1;
                end else begin
                    rc_d = rc_q + CNT_W'(1);
                end
            end
            HELD_REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == RP_LAST) begin
                    rc_d  = '0;
                    rpt_d = 1'b1;
                end else begin
                    rc_d = rc_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            dc_q    <= '0;
            rc_q    <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rpt_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= sync_d;
            dc_q    <= dc_d;
            rc_q    <= rc_d;
            level_q <= level_d;
            press_q <= press_d;
            rpt_q   <= rpt_d;
            state_q <= state_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign rpt        = rpt_q;
    assign press_next = press_d;
    assign rpt_next   = rpt_d;

endmodule

// File: rtl/button_event_conditioner.sv
// Conditions the board push-buttons into clean levels, press / repeat pulses
// and sticky event flags that the core clears with a masked acknowledge.
module button_event_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN       = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] iButtons,
    input  logic               iAck,
    input  logic [NUM_BTN-1:0] iAckMask,
    output logic [NUM_BTN-1:0] oLevel,
    output logic [NUM_BTN-1:0] oPress,
    output logic [NUM_BTN-1:0] oRepeat,
    output logic [NUM_BTN-1:0] oEventFlags,
    output logic               oAnyEvent
);

    if (NUM_BTN < 1 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || CNT_W < 1) begin : g_bad_param
        $error("button_event_conditioner: all parameters must be >= 1");
    end

    if (((DEBOUNCE_CYC - 1) >> CNT_W) != 0 || ((REPEAT_DELAY - 1) >> CNT_W) != 0 ||
        ((REPEAT_PERIOD - 1) >> CNT_W) != 0) begin : g_bad_width
        $error("button_event_conditioner: CNT_W too narrow for timing parameters");
    end

    logic [NUM_BTN-1:0] press_nx, rpt_nx;
    logic [NUM_BTN-1:0] flags_q, flags_d;
    logic               any_q, any_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk       (Clock),
            .rst_n     (Reset),
            .btn_raw   (iButtons[i]),
            .level     (oLevel[i]),
            .press     (oPress[i]),
            .rpt       (oRepeat[i]),
            .press_next(press_nx[i]),
            .rpt_next  (rpt_nx[i])
        );
    end

    // Sets are OR-ed after the clear so an event coinciding with an ack survives.
    always_comb begin
        flags_d = (flags_q & ~(iAck ? iAckMask : '0)) | press_nx | rpt_nx;
        any_d   = |flags_d;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            flags_q <= '0;
            any_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            any_q   <= any_d;
        end
    end

    assign oEventFlags = flags_q;
    assign oAnyEvent   = any_q;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner with a window-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_button_event_conditioner;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic          Clock;
    logic          Reset;
    logic [NB-1:0] iButtons;
    logic          iAck;
    logic [NB-1:0] iAckMask;
    logic [NB-1:0] oLevel, oPress, oRepeat, oEventFlags;
    logic          oAnyEvent;

    int checks   = 0;
    int failures = 0;

    button_event_conditioner #(
        .NUM_BTN      (NB),
        .DEBOUNCE_CYC (DC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (8)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iButtons   (iButtons),
        .iAck       (iAck),
        .iAckMask   (iAckMask),
        .oLevel     (oLevel),
        .oPress     (oPress),
        .oRepeat    (oRepeat),
        .oEventFlags(oEventFlags),
        .oAnyEvent  (oAnyEvent)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: synced sample at edge n is the raw sample of edge n-2; the level
    // flips when the last DC synced samples since the previous flip all disagree with it.
    // Repeats fall at press+RD+m*RP while the level stays high.
    logic [NB-1:0] rawlog[$];
    int            n;
    int            last_tog[NB];
    int            press_at[NB];
    logic [NB-1:0] mlev, exp_level, exp_press, exp_rpt, exp_flags;
    logic          exp_any;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rawlog.delete();
            n = 0;
            mlev = '0;
            exp_level = '0; exp_press = '0; exp_rpt = '0; exp_flags = '0; exp_any = 1'b0;
            for (int i = 0; i < NB; i++) begin
                last_tog[i] = -1;
                press_at[i] = 0;
            end
        end else begin
            logic [NB-1:0] p, r;
            rawlog.push_back(iButtons);
            p = '0;
            r = '0;
            for (int i = 0; i < NB; i++) begin
                bit ok;
                ok = (n - last_tog[i]) >= DC;
                for (int j = 0; j < DC; j++) begin
                    int si;
                    logic sv;
                    si = n - j - 2;
                    sv = (si >= 0) ? rawlog[si][i] : 1'b0;
                    if (sv == mlev[i]) ok = 0;
                end
                if (ok) begin
                    mlev[i] = ~mlev[i];
                    last_tog[i] = n;
                    if (mlev[i]) begin
                        p[i] = 1'b1;
                        press_at[i] = n;
                    end
                end else if (mlev[i]) begin
                    int h;
                    h = n - press_at[i];
                    if (h >= RD && ((h - RD) % RP) == 0) r[i] = 1'b1;
                end
            end
            exp_flags = (exp_flags & ~(iAck ? iAckMask : '0)) | p | r;
            exp_any   = |exp_flags;
            exp_level = mlev;
            exp_press = p;
            exp_rpt   = r;
            n++;
        end
    end

    always @(negedge Clock) begin
        chk("cyc_level", oLevel, exp_level);
        chk("cyc_press", oPress, exp_press);
        chk("cyc_repeat", oRepeat, exp_rpt);
        chk("cyc_flags", oEventFlags, exp_flags);
        chk("cyc_any", oAnyEvent, exp_any);
    end

    task automatic wait_level(input logic [NB-1:0] target, input int max);
        for (int c = 0; c < max && oLevel !== target; c++) @(negedge Clock);
        chk("wait_level", oLevel, target);
    endtask

    task automatic wait_press(input int idx, input int max);
        for (int c = 0; c < max && oPress[idx] !== 1'b1; c++) @(negedge Clock);
        chk("wait_press", oPress[idx], 1);
    endtask

    task automatic pulse_ack(input logic [NB-1:0] m);
        iAck = 1'b1;
        iAckMask = m;
        @(negedge Clock);
        iAck = 1'b0;
        iAckMask = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        int bad;
        int rq[$];
        int late_rpt;

        Reset = 1'b1; iButtons = 4'hF; iAck = 1'b0; iAckMask = '0;
        #1 Reset = 1'b0;

        // 1: buttons held through reset
        repeat (3) @(negedge Clock);
        chk("t1_rst_level", oLevel, 0);
        chk("t1_rst_press", oPress, 0);
        chk("t1_rst_repeat", oRepeat, 0);
        chk("t1_rst_flags", oEventFlags, 0);
        chk("t1_rst_any", oAnyEvent, 0);
        Reset = 1'b1;
        repeat (5) @(negedge Clock);
        chk("t1_level_early", oLevel, 4'h0);
        @(negedge Clock);
        chk("t1_level", oLevel, 4'hF);
        chk("t1_press", oPress, 4'hF);
        chk("t1_flags", oEventFlags, 4'hF);
        chk("t1_any", oAnyEvent, 1);
        @(negedge Clock);
        chk("t1_press_gone", oPress, 4'h0);
        iButtons = '0;
        wait_level(4'h0, 20);
        pulse_ack(4'hF);
        chk("t1_cleared", oEventFlags, 0);

        // 2: bounce on SOUTH
        pc = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            iButtons[0] = ((c / 2) % 2) == 0;
            @(negedge Clock);
            if (oLevel[0]) bad = 1;
            if (oPress[0]) pc++;
        end
        iButtons[0] = 1'b1;
        repeat (5) begin
            @(negedge Clock);
            if (oLevel[0]) bad = 1;
            if (oPress[0]) pc++;
        end
        chk("t2_bounce_low", bad, 0);
        @(negedge Clock);
        chk("t2_level", oLevel[0], 1);
        if (oPress[0]) pc++;
        repeat (3) begin
            @(negedge Clock);
            if (oPress[0]) pc++;
        end
        chk("t2_press_count", pc, 1);
        iButtons[0] = 1'b0;
        wait_level(4'h0, 20);
        pulse_ack(4'hF);

        // 3: hold NORTH; release lands on the edge a repeat would fall due
        iButtons[1] = 1'b1;
        wait_press(1, 20);
        for (int j = 1; j <= 54; j++) begin
            @(negedge Clock);
            if (oRepeat[1]) rq.push_back(j);
        end
        iButtons[1] = 1'b0;
        chk("t3_rpt_count", rq.size(), 5);
        for (int k = 0; k < 5 && k < rq.size(); k++) chk("t3_rpt_at", rq[k], 20 + 8 * k);
        late_rpt = 0;
        for (int j = 55; j <= 70; j++) begin
            @(negedge Clock);
            if (oRepeat[1] || oPress[1]) late_rpt++;
            if (j == 59) chk("t3_level_held", oLevel[1], 1);
            if (j == 60) chk("t3_level_rel", oLevel[1], 0);
        end
        chk("t3_no_late_pulse", late_rpt, 0);
        pulse_ack(4'hF);

        // 4: ack coinciding with repeat on WEST
        iButtons[2] = 1'b1;
        wait_press(2, 20);
        for (int j = 1; j <= 22; j++) begin
            @(negedge Clock);
            if (j == 19) begin iAck = 1'b1; iAckMask = 4'b0100; end
            if (j == 20) begin
                iAck = 1'b0; iAckMask = '0;
                chk("t4_rpt", oRepeat[2], 1);
                chk("t4_flag_kept", oEventFlags[2], 1);
            end
            if (j == 21) begin iAck = 1'b1; iAckMask = 4'b0100; end
            if (j == 22) begin
                iAck = 1'b0; iAckMask = '0;
                chk("t4_flag_clr", oEventFlags, 4'b0000);
                chk("t4_any_clr", oAnyEvent, 0);
            end
        end
        iButtons[2] = 1'b0;
        wait_level(4'h0, 20);
        pulse_ack(4'hF);

        // 5: partial ack
        iButtons = 4'b1011;
        wait_press(0, 20);
        chk("t5_flags_set", oEventFlags, 4'b1011);
        pulse_ack(4'b0011);
        chk("t5_flags_part", oEventFlags, 4'b1000);
        chk("t5_any", oAnyEvent, 1);

        // 6: reset while EAST is auto-repeating
        iButtons = 4'b1000;
        repeat (23) @(negedge Clock);
        chk("t6_held", oLevel, 4'b1000);
        #2 Reset = 1'b0;
        iButtons = '0;
        #1;
        chk("t6_async_level", oLevel, 0);
        chk("t6_async_flags", oEventFlags, 0);
        chk("t6_async_any", oAnyEvent, 0);
        chk("t6_async_pulse", oPress | oRepeat, 0);
        @(negedge Clock);
        Reset = 1'b1;
        late_rpt = 0;
        repeat (30) begin
            @(negedge Clock);
            if (oRepeat != 0 || oPress != 0) late_rpt++;
        end
        chk("t6_no_stale", late_rpt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
